// File: rtl/equeue_generic.sv
// equeue_generic: age-ordered issue queue with CDB capture, collapsing compaction and flush.
// Optional EQUEUE_CDB_BYPASS_EN captures a same-cycle CDB broadcast into a dispatched operand.
module equeue_generic #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic [TAG_W-1:0]  dispatch_rdtag,
  input  logic [TAG_W-1:0]  dispatch_rstag,
  input  logic [TAG_W-1:0]  dispatch_rttag,
  input  logic [DATA_W-1:0] dispatch_rsdata,
  input  logic [DATA_W-1:0] dispatch_rtdata,
  input  logic              dispatch_rsvalid,
  input  logic              dispatch_rtvalid,
  input  logic              dispatch_en,
  output logic              dispatch_ready,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_valid,
  output logic [TAG_W-1:0]  issue_rdtag,
  output logic [DATA_W-1:0] issue_rsdata,
  output logic [DATA_W-1:0] issue_rtdata,
  output logic              issue_ready,
  input  logic              issue_done,
  output logic [CNT_W-1:0]  occupancy
);
  localparam int IW = $clog2(DEPTH);
  typedef struct packed {
    logic              v;
    logic              rsv;
    logic              rtv;
    logic [TAG_W-1:0]  rd;
    logic [TAG_W-1:0]  rs;
    logic [TAG_W-1:0]  rt;
    logic [DATA_W-1:0] rsd;
    logic [DATA_W-1:0] rtd;
  } ent_t;
  ent_t q [DEPTH];
  ent_t up [DEPTH+1];
  ent_t nxt [DEPTH];
  ent_t din;
  logic [CNT_W-1:0] occ, wr_idx;
  logic [IW-1:0] sel;
  logic found, pop, push, byp_rs, byp_rt;
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (q[i].v && q[i].rsv && q[i].rtv) begin
        sel = IW'(i);
        found = 1'b1;
      end
  end
  assign issue_ready    = found & ~flush;
  assign pop            = issue_ready & issue_done;
  assign dispatch_ready = ~flush & ((occ < CNT_W'(DEPTH)) | pop);
  assign push           = dispatch_en & dispatch_ready;
  assign wr_idx         = occ - CNT_W'(pop);
  assign occupancy      = occ;
  assign issue_rdtag    = q[sel].rd;
  assign issue_rsdata   = q[sel].rsd;
  assign issue_rtdata   = q[sel].rtd;
`ifdef EQUEUE_CDB_BYPASS_EN
  assign byp_rs = cdb_valid & ~dispatch_rsvalid & (dispatch_rstag == cdb_tag);
  assign byp_rt = cdb_valid & ~dispatch_rtvalid & (dispatch_rttag == cdb_tag);
`else
  assign byp_rs = 1'b0;
  assign byp_rt = 1'b0;
`endif
  always_comb begin
    din.v   = 1'b1;
    din.rsv = dispatch_rsvalid | byp_rs;
    din.rtv = dispatch_rtvalid | byp_rt;
    din.rd  = dispatch_rdtag;
    din.rs  = dispatch_rstag;
    din.rt  = dispatch_rttag;
    din.rsd = byp_rs ? cdb_data : dispatch_rsdata;
    din.rtd = byp_rt ? cdb_data : dispatch_rtdata;
  end
  // CDB capture happens before the shift so moving entries still wake up
  always_comb begin
    up[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      up[i] = q[i];
      if (cdb_valid && q[i].v && !q[i].rsv && q[i].rs == cdb_tag) begin
        up[i].rsv = 1'b1;
        up[i].rsd = cdb_data;
      end
      if (cdb_valid && q[i].v && !q[i].rtv && q[i].rt == cdb_tag) begin
        up[i].rtv = 1'b1;
        up[i].rtd = cdb_data;
      end
    end
  end
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      nxt[i] = (pop && i >= int'(sel)) ? up[i+1] : up[i];
      if (push && wr_idx == CNT_W'(i)) nxt[i] = din;
      if (flush) nxt[i].v = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      occ <= '0;
      q   <= '{default: '0};
    end else begin
      occ <= flush ? '0 : occ + CNT_W'(push) - CNT_W'(pop);
      q   <= nxt;
    end
endmodule

// File: tb/tb_equeue_generic.sv
// tb_equeue_generic: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_equeue_generic;
  localparam int DEPTH = 4, TAG_W = 6, DATA_W = 32, CNT_W = 3;
  logic clk = 0, reset_n = 0, flush = 0;
  logic [TAG_W-1:0] dispatch_rdtag, dispatch_rstag, dispatch_rttag, cdb_tag, issue_rdtag;
  logic [DATA_W-1:0] dispatch_rsdata, dispatch_rtdata, cdb_data, issue_rsdata, issue_rtdata;
  logic dispatch_rsvalid, dispatch_rtvalid, dispatch_en, dispatch_ready, cdb_valid, issue_ready, issue_done;
  logic [CNT_W-1:0] occupancy;
  int errs = 0, checks = 0;

  equeue_generic #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .dispatch_rdtag(dispatch_rdtag), .dispatch_rstag(dispatch_rstag), .dispatch_rttag(dispatch_rttag),
    .dispatch_rsdata(dispatch_rsdata), .dispatch_rtdata(dispatch_rtdata),
    .dispatch_rsvalid(dispatch_rsvalid), .dispatch_rtvalid(dispatch_rtvalid),
    .dispatch_en(dispatch_en), .dispatch_ready(dispatch_ready),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_valid(cdb_valid),
    .issue_rdtag(issue_rdtag), .issue_rsdata(issue_rsdata), .issue_rtdata(issue_rtdata),
    .issue_ready(issue_ready), .issue_done(issue_done), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0]  rd, rs, rt;
    logic [DATA_W-1:0] rsd, rtd;
    logic              rsv, rtv;
  } me_t;
  me_t mq[$];

  function automatic int m_sel();
    foreach (mq[i]) if (mq[i].rsv && mq[i].rtv) return i;
    return -1;
  endfunction

  task automatic idle();
    flush = 0; dispatch_en = 0; cdb_valid = 0; issue_done = 0;
    dispatch_rdtag = 0; dispatch_rstag = 0; dispatch_rttag = 0;
    dispatch_rsdata = 0; dispatch_rtdata = 0; dispatch_rsvalid = 0; dispatch_rtvalid = 0;
    cdb_tag = 0; cdb_data = 0;
  endtask

  task automatic disp(input int rd, input int rs, input int rt, input logic [DATA_W-1:0] rsd,
                      input logic [DATA_W-1:0] rtd, input logic rsv, input logic rtv);
    dispatch_en = 1; dispatch_rdtag = TAG_W'(rd); dispatch_rstag = TAG_W'(rs); dispatch_rttag = TAG_W'(rt);
    dispatch_rsdata = rsd; dispatch_rtdata = rtd; dispatch_rsvalid = rsv; dispatch_rtvalid = rtv;
  endtask

  // Advances the reference model by one clock using the currently driven inputs, then the DUT.
  task automatic cyc();
    int s;
    bit pop, push;
    me_t n;
    s = m_sel();
    pop = s >= 0 && !flush && issue_done;
    push = dispatch_en && !flush && (mq.size() < DEPTH || pop);
    n = '{dispatch_rdtag, dispatch_rstag, dispatch_rttag, dispatch_rsdata, dispatch_rtdata,
          dispatch_rsvalid, dispatch_rtvalid};
`ifdef EQUEUE_CDB_BYPASS_EN
    if (cdb_valid && !n.rsv && n.rs == cdb_tag) begin n.rsv = 1; n.rsd = cdb_data; end
    if (cdb_valid && !n.rtv && n.rt == cdb_tag) begin n.rtv = 1; n.rtd = cdb_data; end
`endif
    if (cdb_valid)
      foreach (mq[i]) begin
        if (!mq[i].rsv && mq[i].rs == cdb_tag) begin mq[i].rsv = 1; mq[i].rsd = cdb_data; end
        if (!mq[i].rtv && mq[i].rt == cdb_tag) begin mq[i].rtv = 1; mq[i].rtd = cdb_data; end
      end
    if (pop) mq.delete(s);
    if (push) mq.push_back(n);
    if (flush) mq.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); reset_n = 0; #2;
    checks++; if (occupancy !== 0) begin errs++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if (issue_ready !== 0) begin errs++; $display("FAIL reset_ir got=%b exp=0", issue_ready); end
    checks++; if (dispatch_ready !== 1) begin errs++; $display("FAIL reset_dr got=%b exp=1", dispatch_ready); end
    checks++; if (issue_rdtag !== 0 || issue_rsdata !== 0 || issue_rtdata !== 0) begin errs++;
      $display("FAIL reset_data got=%0h/%0h/%0h exp=0/0/0", issue_rdtag, issue_rsdata, issue_rtdata); end
    @(posedge clk); #1; reset_n = 1; mq.delete();
  endtask

  task automatic test_fill_and_full_pop();
    for (int k = 1; k <= 4; k++) begin disp(k, 0, 0, DATA_W'(k * 16), DATA_W'(k * 256), 1, 1); cyc(); end
    idle(); #1;
    checks++; if (occupancy !== 4) begin errs++; $display("FAIL fill_occ got=%0d exp=4", occupancy); end
    checks++; if (dispatch_ready !== 0) begin errs++; $display("FAIL fill_dr got=%b exp=0", dispatch_ready); end
    checks++; if (issue_ready !== 1 || issue_rdtag !== 1) begin errs++;
      $display("FAIL fill_head got=%b/%0d exp=1/1", issue_ready, issue_rdtag); end
    issue_done = 1; disp(5, 0, 0, 32'h50, 32'h500, 1, 1); #1;
    checks++; if (dispatch_ready !== 1) begin errs++; $display("FAIL full_pop_dr got=%b exp=1", dispatch_ready); end
    cyc(); idle(); #1;
    checks++; if (occupancy !== 4) begin errs++; $display("FAIL full_pop_occ got=%0d exp=4", occupancy); end
    for (int k = 2; k <= 5; k++) begin
      issue_done = 1; #1;
      checks++; if (issue_ready !== 1 || issue_rdtag !== TAG_W'(k) || issue_rsdata !== DATA_W'(k * 16)
                    || issue_rtdata !== DATA_W'(k * 256)) begin errs++;
        $display("FAIL drain_order got=%b/%0d/%0h/%0h exp=1/%0d/%0h/%0h", issue_ready, issue_rdtag,
                 issue_rsdata, issue_rtdata, k, k * 16, k * 256); end
      cyc();
    end
    idle(); #1;
    checks++; if (occupancy !== 0 || issue_ready !== 0) begin errs++;
      $display("FAIL drain_empty got=%0d/%b exp=0/0", occupancy, issue_ready); end
  endtask

  task automatic test_wakeup();
    disp(7, 9, 1, 0, 32'h77, 0, 1); cyc();
    disp(8, 2, 3, 32'h81, 32'h82, 1, 1); cyc();
    idle(); #1;
    checks++; if (issue_ready !== 1 || issue_rdtag !== 8) begin errs++;
      $display("FAIL wake_younger got=%b/%0d exp=1/8", issue_ready, issue_rdtag); end
    issue_done = 1; cyc();
    idle(); cdb_valid = 1; cdb_tag = 9; cdb_data = 32'hDEAD; #1;
    checks++; if (issue_ready !== 0) begin errs++; $display("FAIL wake_latency got=%b exp=0", issue_ready); end
    cyc(); idle(); #1;
    checks++; if (issue_ready !== 1 || issue_rdtag !== 7 || issue_rsdata !== 32'hDEAD || issue_rtdata !== 32'h77)
      begin errs++; $display("FAIL wake_capture got=%b/%0d/%0h/%0h exp=1/7/dead/77", issue_ready, issue_rdtag,
                             issue_rsdata, issue_rtdata); end
    issue_done = 1; cyc(); idle();
  endtask

  task automatic test_no_overwrite();
    disp(10, 3, 4, 32'h1234, 32'h5678, 1, 1); cyc();
    idle(); cdb_valid = 1; cdb_tag = 3; cdb_data = 32'h1; cyc();
    idle(); #1;
    checks++; if (issue_ready !== 1 || issue_rsdata !== 32'h1234) begin errs++;
      $display("FAIL no_overwrite got=%b/%0h exp=1/1234", issue_ready, issue_rsdata); end
    issue_done = 1; cyc(); idle();
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin disp(14 + k, 0, 0, 1, 2, 1, 1); cyc(); end
    idle(); flush = 1; issue_done = 1; disp(20, 0, 0, 5, 6, 1, 1); #1;
    checks++; if (issue_ready !== 0 || dispatch_ready !== 0) begin errs++;
      $display("FAIL flush_comb got=%b/%b exp=0/0", issue_ready, dispatch_ready); end
    cyc(); idle(); #1;
    checks++; if (occupancy !== 0 || issue_ready !== 0) begin errs++;
      $display("FAIL flush_clear got=%0d/%b exp=0/0", occupancy, issue_ready); end
    cyc(); #1;
    checks++; if (occupancy !== 0) begin errs++; $display("FAIL flush_dropped got=%0d exp=0", occupancy); end
  endtask

  task automatic test_bypass();
    disp(11, 12, 1, 0, 32'h66, 0, 1); cdb_valid = 1; cdb_tag = 12; cdb_data = 32'h55; cyc();
    idle(); #1;
`ifdef EQUEUE_CDB_BYPASS_EN
    checks++; if (issue_ready !== 1 || issue_rdtag !== 11 || issue_rsdata !== 32'h55) begin errs++;
      $display("FAIL bypass_on got=%b/%0d/%0h exp=1/11/55", issue_ready, issue_rdtag, issue_rsdata); end
`else
    checks++; if (issue_ready !== 0 || occupancy !== 1) begin errs++;
      $display("FAIL bypass_off got=%b/%0d exp=0/1", issue_ready, occupancy); end
`endif
    flush = 1; cyc(); idle();
  endtask

  task automatic test_random();
    int s;
    bit eir, edr;
    for (int n = 0; n < 3000; n++) begin
      idle();
      flush = ($urandom_range(0, 31) == 0);
      issue_done = $urandom_range(0, 1);
      if ($urandom_range(0, 2) != 0)
        disp($urandom_range(0, 63), $urandom_range(0, 7), $urandom_range(0, 7), $urandom, $urandom,
             $urandom_range(0, 1), $urandom_range(0, 1));
      cdb_valid = $urandom_range(0, 1); cdb_tag = TAG_W'($urandom_range(0, 7)); cdb_data = $urandom;
      #1;
      s = m_sel();
      eir = s >= 0 && !flush;
      edr = !flush && (mq.size() < DEPTH || (eir && issue_done));
      checks++; if (issue_ready !== eir) begin errs++;
        $display("FAIL rnd_ir cyc=%0d got=%b exp=%b", n, issue_ready, eir); end
      checks++; if (dispatch_ready !== edr) begin errs++;
        $display("FAIL rnd_dr cyc=%0d got=%b exp=%b", n, dispatch_ready, edr); end
      checks++; if (occupancy !== CNT_W'(mq.size())) begin errs++;
        $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", n, occupancy, mq.size()); end
      if (eir) begin
        checks++; if (issue_rdtag !== mq[s].rd || issue_rsdata !== mq[s].rsd || issue_rtdata !== mq[s].rtd) begin
          errs++; $display("FAIL rnd_issue cyc=%0d got=%0d/%0h/%0h exp=%0d/%0h/%0h", n, issue_rdtag,
                           issue_rsdata, issue_rtdata, mq[s].rd, mq[s].rsd, mq[s].rtd); end
      end
      cyc();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill_and_full_pop();
    test_wakeup();
    test_no_overwrite();
    test_flush();
    test_bypass();
    test_random();
    disp(30, 0, 0, 1, 1, 1, 1); cyc(); idle();
    #3; reset_n = 0; #1;
    checks++; if (occupancy !== 0 || issue_ready !== 0 || dispatch_ready !== 1) begin errs++;
      $display("FAIL async_reset got=%0d/%b/%b exp=0/0/1", occupancy, issue_ready, dispatch_ready); end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
